// File: rtl/grid_render_controller.sv
// Grid renderer sequencer: origin-relative coordinates, matched sync/blank/overlay delay, final pixel composite.
// Optional build macro GRID_CTRL_BLEND_EN: average an opaque overlay with the grid layer instead of replacing it.
module grid_render_controller #(
    parameter int          GRID_LATENCY = 1,
    parameter logic [10:0] X_ORIGIN_RST = 11'd512,
    parameter logic [9:0]  Y_ORIGIN_RST = 10'd767
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [10:0] hcount,
    input  logic [9:0]  vcount,
    input  logic        hsync,
    input  logic        vsync,
    input  logic        blank,
    input  logic [10:0] cfg_x_origin,
    input  logic [9:0]  cfg_y_origin,
    input  logic        cfg_valid,
    output logic        cfg_ready,
    output logic [11:0] grid_x,
    output logic [11:0] grid_y,
    input  logic [23:0] grid_pixel,
    input  logic        grid_en,
    input  logic [23:0] overlay_pixel,
    input  logic        overlay_valid,
    output logic        phsync,
    output logic        pvsync,
    output logic        pblank,
    output logic [23:0] pixel,
    output logic        frame_done
);

    typedef enum logic {READY, PENDING} cfg_state_t;

    // Delay bundle layout: {hsync, vsync, blank, overlay_valid, overlay_pixel}
    localparam int          DW      = 28;
    localparam logic [DW-1:0] DLY_RST = {1'b1, 1'b1, 1'b1, 1'b0, 24'h000000};

    cfg_state_t  state_reg, state_next;
    logic        capture, apply;
    logic        vsync_reg;
    logic        frame_boundary;
    logic        frame_done_reg;
    logic [10:0] x_origin_reg, x_shadow_reg;
    logic [9:0]  y_origin_reg, y_shadow_reg;
    logic [11:0] grid_x_reg, grid_y_reg;

    logic [GRID_LATENCY:0][DW-1:0] dly_reg;
    logic [DW-1:0] raster_bundle;
    logic [DW-1:0] dly_out;

    logic        d_hsync, d_vsync, d_blank, d_ovalid;
    logic [23:0] d_overlay;
    logic [23:0] grid_layer, overlay_layer;
    logic [23:0] pixel_next;
    logic [23:0] pixel_reg;
    logic        phsync_reg, pvsync_reg, pblank_reg;

    assign frame_boundary = vsync_reg & ~vsync;

    always_comb begin
        state_next = state_reg;
        capture    = 1'b0;
        apply      = 1'b0;
        case (state_reg)
            READY: begin
                if (cfg_valid) begin
                    capture    = 1'b1;
                    state_next = PENDING;
                end
            end
            PENDING: begin
                if (frame_boundary) begin
                    apply      = 1'b1;
                    state_next = READY;
                end
            end
            default: state_next = READY;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_reg      <= READY;
            vsync_reg      <= 1'b1;
            frame_done_reg <= 1'b0;
            x_origin_reg   <= X_ORIGIN_RST;
            y_origin_reg   <= Y_ORIGIN_RST;
            x_shadow_reg   <= '0;
            y_shadow_reg   <= '0;
        end else begin
            state_reg      <= state_next;
            vsync_reg      <= vsync;
            frame_done_reg <= frame_boundary;
            if (capture) begin
                x_shadow_reg <= cfg_x_origin;
                y_shadow_reg <= cfg_y_origin;
            end
            // Stage 1 below still sees the old origin this edge; the new one takes effect next sample.
            if (apply) begin
                x_origin_reg <= x_shadow_reg;
                y_origin_reg <= y_shadow_reg;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            grid_x_reg <= '0;
            grid_y_reg <= '0;
        end else begin
            grid_x_reg <= {1'b0, hcount} - {1'b0, x_origin_reg};
            grid_y_reg <= {2'b0, y_origin_reg} - {2'b0, vcount};
        end
    end

    // Stage 1 plus GRID_LATENCY stages, so the bundle lines up with grid_pixel at the final stage.
    assign raster_bundle = {hsync, vsync, blank, overlay_valid, overlay_pixel};

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            dly_reg <= {(GRID_LATENCY + 1){DLY_RST}};
        end else begin
            dly_reg[0] <= raster_bundle;
            for (int i = 1; i <= GRID_LATENCY; i++) begin
                dly_reg[i] <= dly_reg[i-1];
            end
        end
    end

    assign dly_out = dly_reg[GRID_LATENCY];
    assign {d_hsync, d_vsync, d_blank, d_ovalid, d_overlay} = dly_out;

    assign grid_layer = grid_en ? grid_pixel : 24'h000000;

`ifdef GRID_CTRL_BLEND_EN
    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_blend
            assign overlay_layer[gi*8 +: 8] = {1'b0, d_overlay[gi*8+1 +: 7]}
                                            + {1'b0, grid_layer[gi*8+1 +: 7]};
        end
    endgenerate
`else
    assign overlay_layer = d_overlay;
`endif

    always_comb begin
        pixel_next = grid_layer;
        if (d_blank) begin
            pixel_next = 24'h000000;
        end else if (d_ovalid) begin
            pixel_next = overlay_layer;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pixel_reg  <= '0;
            phsync_reg <= 1'b1;
            pvsync_reg <= 1'b1;
            pblank_reg <= 1'b1;
        end else begin
            pixel_reg  <= pixel_next;
            phsync_reg <= d_hsync;
            pvsync_reg <= d_vsync;
            pblank_reg <= d_blank;
        end
    end

    assign cfg_ready  = (state_reg == READY);
    assign grid_x     = grid_x_reg;
    assign grid_y     = grid_y_reg;
    assign pixel      = pixel_reg;
    assign phsync     = phsync_reg;
    assign pvsync     = pvsync_reg;
    assign pblank     = pblank_reg;
    assign frame_done = frame_done_reg;

endmodule

// File: tb/tb_grid_render_controller.sv
// Directed bench for grid_render_controller: reset, coordinates, pipeline alignment, overlay, origin handshake.
module tb_grid_render_controller;

    logic        clock = 1'b0;
    logic        reset;
    logic [10:0] hcount;
    logic [9:0]  vcount;
    logic        hsync, vsync, blank;
    logic [10:0] cfg_x_origin;
    logic [9:0]  cfg_y_origin;
    logic        cfg_valid;
    logic        cfg_ready;
    logic [11:0] grid_x, grid_y;
    logic [23:0] grid_pixel;
    logic        grid_en;
    logic [23:0] overlay_pixel;
    logic        overlay_valid;
    logic        phsync, pvsync, pblank;
    logic [23:0] pixel;
    logic        frame_done;

    int tests_run    = 0;
    int tests_failed = 0;

`ifdef GRID_CTRL_BLEND_EN
    localparam logic [23:0] OVL_EXP = 24'h7F7F00;
`else
    localparam logic [23:0] OVL_EXP = 24'hFF0000;
`endif

    grid_render_controller dut (
        .clock         (clock),
        .reset         (reset),
        .hcount        (hcount),
        .vcount        (vcount),
        .hsync         (hsync),
        .vsync         (vsync),
        .blank         (blank),
        .cfg_x_origin  (cfg_x_origin),
        .cfg_y_origin  (cfg_y_origin),
        .cfg_valid     (cfg_valid),
        .cfg_ready     (cfg_ready),
        .grid_x        (grid_x),
        .grid_y        (grid_y),
        .grid_pixel    (grid_pixel),
        .grid_en       (grid_en),
        .overlay_pixel (overlay_pixel),
        .overlay_valid (overlay_valid),
        .phsync        (phsync),
        .pvsync        (pvsync),
        .pblank        (pblank),
        .pixel         (pixel),
        .frame_done    (frame_done)
    );

    always #5 clock = ~clock;

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic test_reset;
        reset = 1'b1;
        tick(2);
        reset  = 1'b0;
        hcount = 11'd600;
        vcount = 10'd300;
        tick(4);
        tests_run++;
        if (pixel !== 24'h00FF00) begin tests_failed++; $display("FAIL pre_reset_pixel: got %h expected %h", pixel, 24'h00FF00); end
        tests_run++;
        if (grid_x !== 12'h058) begin tests_failed++; $display("FAIL pre_reset_grid_x: got %h expected %h", grid_x, 12'h058); end
        // Assert reset between clock edges; outputs must clear without waiting for an edge.
        #2;
        reset = 1'b1;
        #1;
        tests_run++;
        if (pixel !== 24'h0) begin tests_failed++; $display("FAIL reset_pixel: got %h expected %h", pixel, 24'h0); end
        tests_run++;
        if (grid_x !== 12'h0 || grid_y !== 12'h0) begin tests_failed++; $display("FAIL reset_grid_xy: got %h/%h expected 000/000", grid_x, grid_y); end
        tests_run++;
        if ({phsync, pvsync, pblank} !== 3'b111) begin tests_failed++; $display("FAIL reset_syncs: got %b expected 111", {phsync, pvsync, pblank}); end
        tests_run++;
        if (cfg_ready !== 1'b1 || frame_done !== 1'b0) begin tests_failed++; $display("FAIL reset_cfg: got ready=%b done=%b expected ready=1 done=0", cfg_ready, frame_done); end
        @(posedge clock);
        #1;
        reset  = 1'b0;
        hcount = 11'd512;
        vcount = 10'd767;
        tick();
        tests_run++;
        if (grid_x !== 12'h000 || grid_y !== 12'h000) begin tests_failed++; $display("FAIL reset_origin: got %h/%h expected 000/000", grid_x, grid_y); end
        tests_run++;
        if (cfg_ready !== 1'b1) begin tests_failed++; $display("FAIL reset_release_ready: got %b expected 1", cfg_ready); end
        $display("[TB] test_reset done");
    endtask

    task automatic test_coords;
        hcount = 11'd0;
        vcount = 10'd0;
        tick();
        tests_run++;
        if (grid_x !== 12'hE00 || grid_y !== 12'h2FF) begin tests_failed++; $display("FAIL coords_zero: got %h/%h expected E00/2FF", grid_x, grid_y); end
        hcount = 11'd1023;
        vcount = 10'd100;
        tick();
        tests_run++;
        if (grid_x !== 12'h1FF || grid_y !== 12'h29B) begin tests_failed++; $display("FAIL coords_mid: got %h/%h expected 1FF/29B", grid_x, grid_y); end
        $display("[TB] test_coords done");
    endtask

    task automatic test_blank;
        tick(4);
        blank = 1'b1;
        hsync = 1'b0;
        tick();
        blank = 1'b0;
        hsync = 1'b1;
        tests_run++;
        if (pblank !== 1'b0 || pixel !== 24'h00FF00) begin tests_failed++; $display("FAIL blank_t1: got pblank=%b pixel=%h expected 0/00FF00", pblank, pixel); end
        tick();
        tests_run++;
        if (pblank !== 1'b0 || phsync !== 1'b1) begin tests_failed++; $display("FAIL blank_t2: got pblank=%b phsync=%b expected 0/1", pblank, phsync); end
        tick();
        tests_run++;
        if (pblank !== 1'b1 || pixel !== 24'h000000) begin tests_failed++; $display("FAIL blank_t3: got pblank=%b pixel=%h expected 1/000000", pblank, pixel); end
        tests_run++;
        if (phsync !== 1'b0) begin tests_failed++; $display("FAIL hsync_t3: got %b expected 0", phsync); end
        tick();
        tests_run++;
        if (pblank !== 1'b0 || pixel !== 24'h00FF00 || phsync !== 1'b1) begin tests_failed++; $display("FAIL blank_t4: got pblank=%b pixel=%h phsync=%b expected 0/00FF00/1", pblank, pixel, phsync); end
        grid_en = 1'b0;
        tick();
        grid_en = 1'b1;
        tests_run++;
        if (pixel !== 24'h000000) begin tests_failed++; $display("FAIL grid_en_off: got %h expected 000000", pixel); end
        tick();
        tests_run++;
        if (pixel !== 24'h00FF00) begin tests_failed++; $display("FAIL grid_en_on: got %h expected 00FF00", pixel); end
        $display("[TB] test_blank done");
    endtask

    task automatic test_overlay;
        overlay_valid = 1'b1;
        overlay_pixel = 24'hFF0000;
        tick();
        overlay_valid = 1'b0;
        overlay_pixel = 24'h000000;
        tick();
        tests_run++;
        if (pixel !== 24'h00FF00) begin tests_failed++; $display("FAIL overlay_t2: got %h expected 00FF00", pixel); end
        tick();
        tests_run++;
        if (pixel !== OVL_EXP) begin tests_failed++; $display("FAIL overlay_t3: got %h expected %h", pixel, OVL_EXP); end
        tick();
        tests_run++;
        if (pixel !== 24'h00FF00) begin tests_failed++; $display("FAIL overlay_t4: got %h expected 00FF00", pixel); end
        $display("[TB] test_overlay done");
    endtask

    task automatic test_config;
        cfg_x_origin = 11'd100;
        cfg_y_origin = 10'd200;
        cfg_valid    = 1'b1;
        tick();
        cfg_valid = 1'b0;
        tests_run++;
        if (cfg_ready !== 1'b0) begin tests_failed++; $display("FAIL cfg_ready_drop: got %b expected 0", cfg_ready); end
        hcount = 11'd100;
        vcount = 10'd200;
        tick(2);
        tests_run++;
        if (grid_x !== 12'hE64 || grid_y !== 12'h237) begin tests_failed++; $display("FAIL cfg_held_origin: got %h/%h expected E64/237", grid_x, grid_y); end
        vsync = 1'b0;
        tick();
        tests_run++;
        if (frame_done !== 1'b1 || cfg_ready !== 1'b1) begin tests_failed++; $display("FAIL cfg_boundary: got done=%b ready=%b expected 1/1", frame_done, cfg_ready); end
        tests_run++;
        if (grid_x !== 12'hE64) begin tests_failed++; $display("FAIL cfg_boundary_x: got %h expected E64", grid_x); end
        tick();
        tests_run++;
        if (grid_x !== 12'h000 || grid_y !== 12'h000) begin tests_failed++; $display("FAIL cfg_applied: got %h/%h expected 000/000", grid_x, grid_y); end
        tests_run++;
        if (frame_done !== 1'b0) begin tests_failed++; $display("FAIL frame_done_once: got %b expected 0", frame_done); end
        $display("[TB] test_config done");
    endtask

    task automatic test_same_cycle;
        vsync = 1'b1;
        tick(2);
        vsync        = 1'b0;
        cfg_x_origin = 11'd300;
        cfg_y_origin = 10'd400;
        cfg_valid    = 1'b1;
        tick();
        tests_run++;
        if (frame_done !== 1'b1 || cfg_ready !== 1'b0) begin tests_failed++; $display("FAIL same_cycle_capture: got done=%b ready=%b expected 1/0", frame_done, cfg_ready); end
        // Second request while pending must be ignored.
        cfg_x_origin = 11'd5;
        cfg_y_origin = 10'd6;
        tick();
        tests_run++;
        if (grid_x !== 12'h000 || grid_y !== 12'h000) begin tests_failed++; $display("FAIL same_cycle_not_applied: got %h/%h expected 000/000", grid_x, grid_y); end
        tick(2);
        vsync = 1'b1;
        tick(2);
        tests_run++;
        if (cfg_ready !== 1'b0 || grid_x !== 12'h000 || frame_done !== 1'b0) begin tests_failed++; $display("FAIL pending_hold: got ready=%b x=%h done=%b expected 0/000/0", cfg_ready, grid_x, frame_done); end
        vsync = 1'b0;
        tick();
        cfg_valid = 1'b0;
        tests_run++;
        if (frame_done !== 1'b1 || cfg_ready !== 1'b1) begin tests_failed++; $display("FAIL next_boundary: got done=%b ready=%b expected 1/1", frame_done, cfg_ready); end
        hcount = 11'd300;
        vcount = 10'd400;
        tick();
        tests_run++;
        if (grid_x !== 12'h000 || grid_y !== 12'h000) begin tests_failed++; $display("FAIL first_request_applied: got %h/%h expected 000/000", grid_x, grid_y); end
        vsync = 1'b1;
        tick();
        $display("[TB] test_same_cycle done");
    endtask

    initial begin
        reset         = 1'b1;
        hcount        = '0;
        vcount        = '0;
        hsync         = 1'b1;
        vsync         = 1'b1;
        blank         = 1'b0;
        cfg_x_origin  = '0;
        cfg_y_origin  = '0;
        cfg_valid     = 1'b0;
        grid_pixel    = 24'h00FF00;
        grid_en       = 1'b1;
        overlay_pixel = '0;
        overlay_valid = 1'b0;
        #1;
        test_reset();
        test_coords();
        test_blank();
        test_overlay();
        test_config();
        test_same_cycle();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
